// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator for the decode stage.
// Decodes the immediate for RV32/RV64 base formats, CSR zimm and selected RVC
// formats, then carries it with an illegal flag and a sideband tag through a
// one-cycle output register backed by a skid register (valid/ready handshake).
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int EN_C  = 1,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [3:0]       imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic             illegal,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  ext_imm;
    logic             ext_ill;

    logic             out_valid_q;
    logic [XLEN-1:0]  out_imm_q;
    logic             out_ill_q;
    logic [TAG_W-1:0] out_tag_q;

    logic             skid_valid_q;
    logic [XLEN-1:0]  skid_imm_q;
    logic             skid_ill_q;
    logic [TAG_W-1:0] skid_tag_q;

    logic             accept;
    logic             drain;
    logic             rvc_en;

    // The opcode size bits never contribute to any immediate.
    logic             unused_bits;
    assign unused_bits = ^instr[1:0];

    assign rvc_en = (EN_C != 0);

    // Decode and extend the immediate selected by imm_src from the raw instruction.
    always_comb begin
        ext_imm = '0;
        ext_ill = 1'b0;
        case (imm_src)
            4'd0: ext_imm = XLEN'($signed(instr[31:20]));
            4'd1: ext_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            4'd2: ext_imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                           instr[11:8], 1'b0}));
            4'd3: ext_imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                           instr[30:21], 1'b0}));
            4'd4: ext_imm = XLEN'($signed({instr[31:12], 12'b0}));
            4'd5: ext_imm = XLEN'(instr[19:15]);
            4'd6: begin
                if (rvc_en) ext_imm = XLEN'($signed({instr[12], instr[6:2]}));
                else        ext_ill = 1'b1;
            end
            4'd7: begin
                if (rvc_en) ext_imm = XLEN'($signed({instr[12], instr[8], instr[10:9],
                                                     instr[6], instr[7], instr[2],
                                                     instr[11], instr[5:3], 1'b0}));
                else        ext_ill = 1'b1;
            end
            4'd8: begin
                if (rvc_en) ext_imm = XLEN'($signed({instr[12], instr[6:5], instr[2],
                                                     instr[11:10], instr[4:3], 1'b0}));
                else        ext_ill = 1'b1;
            end
            4'd9: begin
                if (rvc_en) ext_imm = XLEN'({instr[5], instr[12:10], instr[6], 2'b00});
                else        ext_ill = 1'b1;
            end
            default: ext_ill = 1'b1;
        endcase
    end

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid_q & out_ready;

    // Output/skid storage: skid refills the output first, so order is kept;
    // accept and skid-refill never coincide because in_ready is low while skid is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_ill_q    <= 1'b0;
            out_tag_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_ill_q   <= 1'b0;
            skid_tag_q   <= '0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (drain || !out_valid_q) begin
            if (skid_valid_q) begin
                out_valid_q  <= 1'b1;
                out_imm_q    <= skid_imm_q;
                out_ill_q    <= skid_ill_q;
                out_tag_q    <= skid_tag_q;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                out_valid_q <= 1'b1;
                out_imm_q   <= ext_imm;
                out_ill_q   <= ext_ill;
                out_tag_q   <= in_tag;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_valid_q <= 1'b1;
            skid_imm_q   <= ext_imm;
            skid_ill_q   <= ext_ill;
            skid_tag_q   <= in_tag;
        end
    end

    assign out_valid = out_valid_q;
    assign imm       = out_imm_q;
    assign illegal   = out_ill_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe: three instances (RV32,
// RV64, RV32 without RVC) share one stimulus stream.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic [3:0]  imm_src;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_illegal;
    logic [31:0] a_imm;
    logic [7:0]  a_out_tag;
    logic        b_in_ready, b_out_valid, b_illegal;
    logic [63:0] b_imm;
    logic [7:0]  b_out_tag;
    logic        c_in_ready, c_out_valid, c_illegal;
    logic [31:0] c_imm;
    logic [7:0]  c_out_tag;

    int tests;
    int fails;

    imm_gen_pipe #(.XLEN(32), .EN_C(1), .TAG_W(8)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(a_in_ready), .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
        .out_valid(a_out_valid), .out_ready(out_ready), .imm(a_imm),
        .illegal(a_illegal), .out_tag(a_out_tag)
    );

    imm_gen_pipe #(.XLEN(64), .EN_C(1), .TAG_W(8)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(b_in_ready), .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
        .out_valid(b_out_valid), .out_ready(out_ready), .imm(b_imm),
        .illegal(b_illegal), .out_tag(b_out_tag)
    );

    imm_gen_pipe #(.XLEN(32), .EN_C(0), .TAG_W(8)) u32nc (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(c_in_ready), .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
        .out_valid(c_out_valid), .out_ready(out_ready), .imm(c_imm),
        .illegal(c_illegal), .out_tag(c_out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h required %h", name, obs, exp);
        end
    endtask

    // Present one entry for one clock edge, then sample 1 time unit after it.
    task automatic offer(input logic [31:0] i, input logic [3:0] s, input logic [7:0] t);
        instr    = i;
        imm_src  = s;
        in_tag   = t;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        imm_src   = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        #2;
        chk("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, a_in_ready},  64'd1);
        chk("rst_imm",       {32'd0, a_imm},       64'd0);
        chk("rst_illegal",   {63'd0, a_illegal},   64'd0);
        chk("rst_out_tag",   {56'd0, a_out_tag},   64'd0);
        #6;
        rst_n = 1'b1;

        // I-type, all ones
        offer(32'hFFF00093, 4'd0, 8'h11);
        chk("i_valid",   {63'd0, a_out_valid}, 64'd1);
        chk("i_imm32",   {32'd0, a_imm},       64'h0000_0000_FFFF_FFFF);
        chk("i_illegal", {63'd0, a_illegal},   64'd0);
        chk("i_tag",     {56'd0, a_out_tag},   64'h11);
        chk("i_imm64",   b_imm,                64'hFFFF_FFFF_FFFF_FFFF);

        offer(32'h7FF00093, 4'd0, 8'h12);
        chk("i_pos", {32'd0, a_imm}, 64'h7FF);

        offer(32'h00112623, 4'd1, 8'h13);
        chk("s_imm", {32'd0, a_imm}, 64'd12);

        offer(32'hFE000EE3, 4'd2, 8'h14);
        chk("b_imm", {32'd0, a_imm}, 64'hFFFF_FFFC);

        offer(32'hFFFFF06F, 4'd3, 8'h15);
        chk("j_imm", {32'd0, a_imm}, 64'hFFFF_FFFE);

        offer(32'h800000B7, 4'd4, 8'h16);
        chk("u_imm64", b_imm,          64'hFFFF_FFFF_8000_0000);
        chk("u_imm32", {32'd0, a_imm}, 64'h8000_0000);

        offer(32'h000FD073, 4'd5, 8'h17);
        chk("z_imm64", b_imm, 64'h1F);

        offer(32'h00000014, 4'd6, 8'h18);
        chk("ci_imm", {32'd0, a_imm}, 64'd5);

        offer(32'h0000BFFD, 4'd7, 8'h19);
        chk("cj_imm",      {32'd0, a_imm},     64'hFFFF_FFFE);
        chk("cj_illegal",  {63'd0, a_illegal}, 64'd0);
        chk("cj_noc_imm",  {32'd0, c_imm},     64'd0);
        chk("cj_noc_ill",  {63'd0, c_illegal}, 64'd1);
        chk("cj_noc_tag",  {56'd0, c_out_tag}, 64'h19);

        offer(32'h00000C4C, 4'd8, 8'h1A);
        chk("cb_imm", {32'd0, a_imm}, 64'd186);

        offer(32'h00001440, 4'd9, 8'h1B);
        chk("clw_imm", {32'd0, a_imm}, 64'd44);

        offer(32'hFFFFFFFF, 4'd12, 8'h1C);
        chk("src12_ill", {63'd0, a_illegal}, 64'd1);
        chk("src12_imm", {32'd0, a_imm},     64'd0);

        tick();
        chk("idle_valid", {63'd0, a_out_valid}, 64'd0);

        // Backpressure: A to output, B to skid, C held until space opens
        out_ready = 1'b0;
        instr     = 32'h00100093;
        imm_src   = 4'd0;
        in_tag    = 8'hA0;
        in_valid  = 1'b1;
        tick();
        chk("bp_a_ready", {63'd0, a_in_ready}, 64'd1);
        in_tag = 8'hB0;
        tick();
        chk("bp_b_ready", {63'd0, a_in_ready}, 64'd0);
        in_tag = 8'hC0;
        tick();
        chk("bp_hold_tag",   {56'd0, a_out_tag}, 64'hA0);
        chk("bp_hold_ready", {63'd0, a_in_ready}, 64'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_out_b",   {56'd0, a_out_tag}, 64'hB0);
        chk("bp_ready_b", {63'd0, a_in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_out_c",   {56'd0, a_out_tag},   64'hC0);
        chk("bp_valid_c", {63'd0, a_out_valid}, 64'd1);
        tick();
        chk("bp_empty", {63'd0, a_out_valid}, 64'd0);

        // Flush with two buffered entries and a new offer in the same cycle
        out_ready = 1'b0;
        offer(32'h00100093, 4'd0, 8'hD1);
        offer(32'h00100093, 4'd0, 8'hD2);
        chk("fl_full", {63'd0, a_in_ready}, 64'd0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_tag   = 8'hD3;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", {63'd0, a_out_valid}, 64'd0);
        chk("fl_ready", {63'd0, a_in_ready},  64'd1);
        out_ready = 1'b1;
        tick();
        chk("fl_discard", {63'd0, a_out_valid}, 64'd0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        offer(32'hFFF00093, 4'd0, 8'hE1);
        offer(32'hFFF00093, 4'd12, 8'hE2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid",   {63'd0, a_out_valid}, 64'd0);
        chk("ar_ready",   {63'd0, a_in_ready},  64'd1);
        chk("ar_imm",     {32'd0, a_imm},       64'd0);
        chk("ar_illegal", {63'd0, a_illegal},   64'd0);
        chk("ar_tag",     {56'd0, a_out_tag},   64'd0);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("ar_after", {63'd0, a_out_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
